// File: rtl/dc_pkg.sv
// Shared types and helpers for the dc PLL phase-shift sequencer.
// Holds the FSM state encoding, default timing constants and the saturating pending update.
package dc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } ps_state_t;

    localparam int PS_SETTLE_DEFAULT  = 12;
    localparam int PS_TIMEOUT_DEFAULT = 1023;

    typedef struct packed {
        logic signed [31:0] value;
        logic               clip;
    } sat_result_t;

    // Adds delta to cur and clamps to +/-lim; clip flags that a request was lost.
    function automatic sat_result_t pend_update(input int cur, input int delta, input int lim);
        sat_result_t r;
        int          sum;
        sum     = cur + delta;
        r.value = sum;
        r.clip  = 1'b0;
        if (sum > lim) begin
            r.value = lim;
            r.clip  = 1'b1;
        end else if (sum < -lim) begin
            r.value = -lim;
            r.clip  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_ps_ctrl_m.sv
// MMCM dynamic phase-shift sequencer: accumulates step requests and issues them
// one at a time over the PSEN/PSINCDEC/PSDONE handshake with settle gap and timeout.
module pll_ps_ctrl_m
    import dc_pkg::*;
#(
    parameter int PEND_WIDTH = 8,
    parameter int POS_WIDTH  = 16,
    parameter int SETTLE     = PS_SETTLE_DEFAULT,
    parameter int TIMEOUT    = PS_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         ph_inc,
    input  logic                         ph_dec,
    input  logic                         clr_err,
    output logic                         psen,
    output logic                         psincdec,
    input  logic                         psdone,
    output logic                         busy,
    output logic signed [PEND_WIDTH-1:0] pending,
    output logic signed [POS_WIDTH-1:0]  position,
    output logic                         err,
    output logic                         ovf
);

    localparam int CNT_MAX  = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int PEND_LIM = (1 << (PEND_WIDTH - 1)) - 1;

    ps_state_t                    state;
    ps_state_t                    state_next;
    logic [CNT_W-1:0]             cnt;
    logic                         go_issue;
    logic                         wait_done;
    logic                         wait_expire;
    int                           issue_step;
    sat_result_t                  pend_res;
    logic signed [PEND_WIDTH-1:0] pending_next;
    logic                         ovf_set;

    // The step is committed when leaving IDLE, so its direction is fixed by the
    // pending sign at that moment even if later requests flip the sign.
    always_comb begin
        go_issue    = (state == ST_IDLE) && ena && (pending != '0);
        wait_done   = (state == ST_WAIT) && psdone;
        wait_expire = (state == ST_WAIT) && !psdone && (cnt == '0);
        issue_step  = 0;
        if (go_issue) begin
            issue_step = (pending > 0) ? 1 : -1;
        end
        pend_res     = pend_update(int'(pending), int'(ph_inc) - int'(ph_dec) - issue_step, PEND_LIM);
        pending_next = PEND_WIDTH'(pend_res.value);
        ovf_set      = pend_res.clip;
        if (!ena || wait_expire) begin
            pending_next = '0;
            ovf_set      = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (go_issue) state_next = ST_ISSUE;
            ST_ISSUE:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_SETTLE;
                end else if (wait_expire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETTLE: if (cnt == '0) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // One down-counter serves both the WAIT timeout and the SETTLE gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            psen     <= 1'b0;
            psincdec <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            position <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state   <= state_next;
            psen    <= (state_next == ST_ISSUE);
            busy    <= (state_next != ST_IDLE);
            pending <= pending_next;

            if (state == ST_ISSUE) begin
                cnt <= CNT_W'(TIMEOUT - 1);
            end else if (wait_done) begin
                cnt <= CNT_W'(SETTLE - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (go_issue) begin
                psincdec <= (pending > 0);
            end

            if (wait_done) begin
                position <= psincdec ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
            end

            if (wait_expire) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_ps_ctrl_m.sv
// Self-checking bench for pll_ps_ctrl_m: an MMCM responder model plus a psen
// scoreboard that holds the expected step direction of every issued step.
module tb_pll_ps_ctrl_m;

    localparam int PW = 4;
    localparam int QW = 16;
    localparam int ST = 12;
    localparam int TO = 60;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ena = 1'b0;
    logic                 ph_inc = 1'b0;
    logic                 ph_dec = 1'b0;
    logic                 clr_err = 1'b0;
    logic                 psdone = 1'b0;
    logic                 psen;
    logic                 psincdec;
    logic                 busy;
    logic signed [PW-1:0] pending;
    logic signed [QW-1:0] position;
    logic                 err;
    logic                 ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ps_delay = 0;
    int cd = 0;
    int last_done = -1;
    int psen_cnt = 0;
    bit exp_q[$];

    pll_ps_ctrl_m #(
        .PEND_WIDTH(PW),
        .POS_WIDTH (QW),
        .SETTLE    (ST),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ph_inc  (ph_inc),
        .ph_dec  (ph_dec),
        .clr_err (clr_err),
        .psen    (psen),
        .psincdec(psincdec),
        .psdone  (psdone),
        .busy    (busy),
        .pending (pending),
        .position(position),
        .err     (err),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // psen scoreboard and MMCM model; psdone returns ps_delay cycles after psen (0 = never).
    always @(negedge clk) begin
        cyc++;
        if (psen) begin
            psen_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_psen: psen seen with psincdec=%0b, required no psen", psincdec);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (psincdec !== e) begin
                    n_bad++;
                    $display("[TB] FAIL psincdec: got %0b, required %0b", psincdec, e);
                end
            end
            if (last_done >= 0) begin
                n_cmp++;
                if (cyc - last_done < ST + 2) begin
                    n_bad++;
                    $display("[TB] FAIL settle_gap: got %0d cycles, required >= %0d", cyc - last_done, ST + 2);
                end
            end
        end
        if (psdone) psdone = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                psdone    = 1'b1;
                last_done = cyc;
            end
        end
        if (psen && ps_delay > 0) cd = ps_delay;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ena = 1'b1;
        ph_inc = 1'b0;
        ph_dec = 1'b0;
        clr_err = 1'b0;
        ps_delay = 0;
        cd = 0;
        psdone = 1'b0;
        last_done = -1;
        exp_q.delete();
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int max, output bit ok, output int minp);
        ok = 1'b0;
        minp = 0;
        for (int i = 0; i < max; i++) begin
            step();
            if (pending < minp) minp = pending;
            if (!busy && pending == 0 && cd == 0 && !psdone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 7;
        if (psen !== 1'b0)     begin n_bad++; $display("[TB] FAIL reset_psen: got %0b, required 0", psen); end
        if (psincdec !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_psincdec: got %0b, required 0", psincdec); end
        if (busy !== 1'b0)     begin n_bad++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy); end
        if (pending !== 4'sd0) begin n_bad++; $display("[TB] FAIL reset_pending: got %0d, required 0", pending); end
        if (position !== '0)   begin n_bad++; $display("[TB] FAIL reset_position: got %0d, required 0", position); end
        if (err !== 1'b0)      begin n_bad++; $display("[TB] FAIL reset_err: got %0b, required 0", err); end
        if (ovf !== 1'b0)      begin n_bad++; $display("[TB] FAIL reset_ovf: got %0b, required 0", ovf); end
    endtask

    task automatic test_single();
        int base;
        bit found;
        do_reset();
        ps_delay = 12;
        base = psen_cnt;
        exp_q.push_back(1'b1);
        ph_inc = 1'b1;
        step();
        ph_inc = 1'b0;
        n_cmp += 2;
        if (pending !== 4'sd1) begin n_bad++; $display("[TB] FAIL single_pend1: got %0d, required 1", pending); end
        if (psen !== 1'b0)     begin n_bad++; $display("[TB] FAIL single_psen_early: got %0b, required 0", psen); end
        step();
        n_cmp += 3;
        if (psen !== 1'b1)     begin n_bad++; $display("[TB] FAIL single_psen: got %0b, required 1", psen); end
        if (psincdec !== 1'b1) begin n_bad++; $display("[TB] FAIL single_dir: got %0b, required 1", psincdec); end
        if (pending !== 4'sd0) begin n_bad++; $display("[TB] FAIL single_pend0: got %0d, required 0", pending); end
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (psdone) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("[TB] FAIL single_psdone_wait: got no psdone, required one within 40 cycles"); end
        for (int k = 1; k <= ST + 1; k++) begin
            step();
            if (k == 1) begin
                n_cmp++;
                if (position !== 16'sd1) begin n_bad++; $display("[TB] FAIL single_position: got %0d, required 1", position); end
            end
            if (k == ST) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy_hold: got %0b, required 1", busy); end
            end
            if (k == ST + 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_drop: got %0b, required 0", busy); end
            end
        end
        n_cmp += 3;
        if (pending !== 4'sd0)     begin n_bad++; $display("[TB] FAIL single_pend_end: got %0d, required 0", pending); end
        if (psen_cnt - base !== 1) begin n_bad++; $display("[TB] FAIL single_psen_count: got %0d, required 1", psen_cnt - base); end
        if (exp_q.size() !== 0)    begin n_bad++; $display("[TB] FAIL single_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_burst();
        int base;
        int minp;
        int mn;
        bit ok;
        do_reset();
        ps_delay = 5;
        base = psen_cnt;
        repeat (5) exp_q.push_back(1'b0);
        mn = 0;
        ph_dec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pending < mn) mn = pending;
        end
        ph_dec = 1'b0;
        wait_idle(400, ok, minp);
        if (minp < mn) mn = minp;
        n_cmp += 5;
        if (!ok)                    begin n_bad++; $display("[TB] FAIL burst_idle: got still busy, required idle within 400 cycles"); end
        if (mn != -4 && mn != -5)   begin n_bad++; $display("[TB] FAIL burst_peak: got %0d, required -4 or -5", mn); end
        if (psen_cnt - base !== 5)  begin n_bad++; $display("[TB] FAIL burst_psen_count: got %0d, required 5", psen_cnt - base); end
        if (position !== -16'sd5)   begin n_bad++; $display("[TB] FAIL burst_position: got %0d, required -5", position); end
        if (exp_q.size() !== 0)     begin n_bad++; $display("[TB] FAIL burst_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reversal();
        int base;
        int minp;
        bit ok;
        do_reset();
        ps_delay = 20;
        base = psen_cnt;
        exp_q.push_back(1'b1);
        ph_inc = 1'b1;
        repeat (3) step();
        ph_inc = 1'b0;
        repeat (2) step();
        n_cmp += 2;
        if (pending !== 4'sd2) begin n_bad++; $display("[TB] FAIL rev_pend_after_inc: got %0d, required 2", pending); end
        if (busy !== 1'b1)     begin n_bad++; $display("[TB] FAIL rev_busy: got %0b, required 1", busy); end
        ph_dec = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (pending !== 4'sd0) begin n_bad++; $display("[TB] FAIL rev_pend_after_dec: got %0d, required 0", pending); end
        ph_inc = 1'b1;
        step();
        ph_inc = 1'b0;
        ph_dec = 1'b0;
        n_cmp++;
        if (pending !== 4'sd0 || ovf !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rev_double_pulse: got pending=%0d ovf=%0b, required pending=0 ovf=0", pending, ovf);
        end
        wait_idle(200, ok, minp);
        n_cmp += 4;
        if (!ok)                   begin n_bad++; $display("[TB] FAIL rev_idle: got still busy, required idle within 200 cycles"); end
        if (position !== 16'sd1)   begin n_bad++; $display("[TB] FAIL rev_position: got %0d, required 1", position); end
        if (pending !== 4'sd0)     begin n_bad++; $display("[TB] FAIL rev_pending: got %0d, required 0", pending); end
        if (psen_cnt - base !== 1) begin n_bad++; $display("[TB] FAIL rev_psen_count: got %0d, required 1", psen_cnt - base); end
    endtask

    task automatic test_saturation();
        int minp;
        bit ok;
        do_reset();
        ps_delay = 0;
        exp_q.push_back(1'b1);
        ph_inc = 1'b1;
        repeat (10) step();
        ph_inc = 1'b0;
        n_cmp += 3;
        if (pending !== 4'sd7) begin n_bad++; $display("[TB] FAIL sat_pending: got %0d, required 7", pending); end
        if (ovf !== 1'b1)      begin n_bad++; $display("[TB] FAIL sat_ovf: got %0b, required 1", ovf); end
        if (err !== 1'b0)      begin n_bad++; $display("[TB] FAIL sat_err: got %0b, required 0", err); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp += 2;
        if (ovf !== 1'b0)      begin n_bad++; $display("[TB] FAIL sat_ovf_clear: got %0b, required 0", ovf); end
        if (pending !== 4'sd7) begin n_bad++; $display("[TB] FAIL sat_pending_hold: got %0d, required 7", pending); end
        wait_idle(200, ok, minp);
        n_cmp++;
        if (!ok || pending !== 4'sd0) begin
            n_bad++;
            $display("[TB] FAIL sat_cleanup: got idle=%0b pending=%0d, required idle=1 pending=0", ok, pending);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ps_delay = 0;
        exp_q.push_back(1'b1);
        ph_inc = 1'b1;
        step();
        ph_inc = 1'b0;
        step();
        n_cmp++;
        if (psen !== 1'b1) begin n_bad++; $display("[TB] FAIL to_psen: got %0b, required 1", psen); end
        for (int k = 1; k <= TO + 1; k++) begin
            step();
            if (k == TO) begin
                n_cmp++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL to_early: got err=%0b busy=%0b, required err=0 busy=1", err, busy);
                end
            end
            if (k == TO + 1) begin
                n_cmp += 4;
                if (err !== 1'b1)      begin n_bad++; $display("[TB] FAIL to_err: got %0b, required 1", err); end
                if (busy !== 1'b0)     begin n_bad++; $display("[TB] FAIL to_busy: got %0b, required 0", busy); end
                if (pending !== 4'sd0) begin n_bad++; $display("[TB] FAIL to_pending: got %0d, required 0", pending); end
                if (position !== '0)   begin n_bad++; $display("[TB] FAIL to_position: got %0d, required 0", position); end
            end
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL to_err_clear: got %0b, required 0", err); end
    endtask

    task automatic test_reset_ena();
        int base;
        do_reset();
        ps_delay = 8;
        exp_q.push_back(1'b1);
        ph_inc = 1'b1;
        step();
        ph_inc = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_pre_busy: got %0b, required 1", busy); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({psen, psincdec, busy, err, ovf} !== 5'b0 || pending !== 4'sd0 || position !== '0) begin
            n_bad++;
            $display("[TB] FAIL rst_abort: got psen=%0b dir=%0b busy=%0b err=%0b ovf=%0b pend=%0d pos=%0d, required all 0",
                     psen, psincdec, busy, err, ovf, pending, position);
        end
        step();
        rst = 1'b1;
        repeat (20) step();
        n_cmp++;
        if (position !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rst_late_psdone: got pos=%0d busy=%0b, required pos=0 busy=0", position, busy);
        end
        ps_delay = 0;
        base = psen_cnt;
        exp_q.push_back(1'b1);
        ph_inc = 1'b1;
        repeat (4) step();
        ph_inc = 1'b0;
        n_cmp++;
        if (pending !== 4'sd3) begin n_bad++; $display("[TB] FAIL ena_pend3: got %0d, required 3", pending); end
        ena = 1'b0;
        step();
        n_cmp++;
        if (pending !== 4'sd0) begin n_bad++; $display("[TB] FAIL ena_clear: got %0d, required 0", pending); end
        ph_inc = 1'b1;
        step();
        ph_inc = 1'b0;
        n_cmp++;
        if (pending !== 4'sd0) begin n_bad++; $display("[TB] FAIL ena_ignore: got %0d, required 0", pending); end
        repeat (TO + ST + 10) step();
        n_cmp += 2;
        if (busy !== 1'b0)         begin n_bad++; $display("[TB] FAIL ena_busy: got %0b, required 0", busy); end
        if (psen_cnt - base !== 1) begin n_bad++; $display("[TB] FAIL ena_psen_count: got %0d, required 1", psen_cnt - base); end
        ena = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_reversal();
        test_saturation();
        test_timeout();
        test_reset_ena();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
